// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: one-bubble load/ALU
// dependence stall, multi-cycle wrong-path squash, data-memory freeze, perf counters.
module pipeline_hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic             IF_ID_UsesRs1,
    input  logic             IF_ID_UsesRs2,
    input  logic             EX_BranchTaken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned WT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WT_W-1:0] WAIT_LIMIT   = WT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] freeze_cycles_q, freeze_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic freeze;
    logic data_hazard;

    assign freeze = dmem_req && !dmem_ready;

    // Only MEM/WB->EX forwarding exists, so a distance-1 match always costs a bubble.
    assign data_hazard = ID_EX_RegWrite && (ID_EX_RegisterRd != 5'd0) &&
                         ((IF_ID_UsesRs1 && (IF_ID_RegisterRs1 == ID_EX_RegisterRd)) ||
                          (IF_ID_UsesRs2 && (IF_ID_RegisterRs2 == ID_EX_RegisterRd)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            flush_cnt_q     <= '0;
            wait_cnt_q      <= '0;
            stall_cycles_q  <= '0;
            freeze_cycles_q <= '0;
            flush_events_q  <= '0;
            mem_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            stall_cycles_q  <= stall_cycles_d;
            freeze_cycles_q <= freeze_cycles_d;
            flush_events_q  <= flush_events_d;
            mem_timeout_q   <= mem_timeout_d;
        end
    end

    // NOTE: every variable gets a default at the top of a combinational block,
    // otherwise a path that skips an assignment infers a latch.
    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        wait_cnt_d      = '0;
        stall_cycles_d  = stall_cycles_q;
        freeze_cycles_d = freeze_cycles_q;
        flush_events_d  = flush_events_q;
        mem_timeout_d   = mem_timeout_q;

        if (freeze) begin
            freeze_cycles_d = freeze_cycles_q + CNT_W'(1);
            // Saturate so an arbitrarily long freeze cannot wrap the wait counter.
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + WT_W'(1);
            if (wait_cnt_q == WAIT_LIMIT) begin
                mem_timeout_d = 1'b1;
            end
        end else if (EX_BranchTaken) begin
            flush_events_d = flush_events_q + CNT_W'(1);
            if (FLUSH_CYCLES > 1) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FLUSH_RELOAD;
            end else begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        end else if (state_q == ST_FLUSH) begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
            if (flush_cnt_q == FC_W'(1)) begin
                state_d = ST_RUN;
            end
        end else if (data_hazard) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        pc_redirect  = 1'b0;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_write  = 1'b1;
        ID_EX_flush  = 1'b0;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;

        if (rst || freeze) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
        end else if (EX_BranchTaken) begin
            pc_redirect = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            // ID holds a squashed NOP, so no dependence check is needed.
            IF_ID_flush = 1'b1;
        end else if (data_hazard) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign freeze_cycles = freeze_cycles_q;
    assign flush_events  = flush_events_q;
    assign mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller
// (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_pipeline_hazard_controller;

    localparam int unsigned CNT_W = 32;

    // {pc_write, pc_redirect, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_write}
    localparam logic [7:0] C_NORMAL = 8'b1010_1011;
    localparam logic [7:0] C_STALL  = 8'b0000_1111;
    localparam logic [7:0] C_BRANCH = 8'b1111_1111;
    localparam logic [7:0] C_FLUSH  = 8'b1011_1011;
    localparam logic [7:0] C_FROZEN = 8'b0000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             ID_EX_RegWrite;
    logic [4:0]       ID_EX_RegisterRd;
    logic [4:0]       IF_ID_RegisterRs1;
    logic [4:0]       IF_ID_RegisterRs2;
    logic             IF_ID_UsesRs1;
    logic             IF_ID_UsesRs2;
    logic             EX_BranchTaken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             pc_redirect;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_write;
    logic             ID_EX_flush;
    logic             EX_MEM_write;
    logic             MEM_WB_write;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] freeze_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             mem_timeout;
    logic [7:0]       ctrl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign ctrl = {pc_write, pc_redirect, IF_ID_write, IF_ID_flush,
                   ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_write};

    pipeline_hazard_controller #(
        .FLUSH_CYCLES(2),
        .MEM_TIMEOUT (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ID_EX_RegWrite   (ID_EX_RegWrite),
        .ID_EX_RegisterRd (ID_EX_RegisterRd),
        .IF_ID_RegisterRs1(IF_ID_RegisterRs1),
        .IF_ID_RegisterRs2(IF_ID_RegisterRs2),
        .IF_ID_UsesRs1    (IF_ID_UsesRs1),
        .IF_ID_UsesRs2    (IF_ID_UsesRs2),
        .EX_BranchTaken   (EX_BranchTaken),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .pc_write         (pc_write),
        .pc_redirect      (pc_redirect),
        .IF_ID_write      (IF_ID_write),
        .IF_ID_flush      (IF_ID_flush),
        .ID_EX_write      (ID_EX_write),
        .ID_EX_flush      (ID_EX_flush),
        .EX_MEM_write     (EX_MEM_write),
        .MEM_WB_write     (MEM_WB_write),
        .stall_cycles     (stall_cycles),
        .freeze_cycles    (freeze_cycles),
        .flush_events     (flush_events),
        .mem_timeout      (mem_timeout)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        ID_EX_RegWrite    = 1'b0;
        ID_EX_RegisterRd  = 5'd0;
        IF_ID_RegisterRs1 = 5'd0;
        IF_ID_RegisterRs2 = 5'd0;
        IF_ID_UsesRs1     = 1'b0;
        IF_ID_UsesRs2     = 1'b0;
        EX_BranchTaken    = 1'b0;
        dmem_req          = 1'b0;
        dmem_ready        = 1'b0;
    endtask

    task automatic set_dep(input logic wr, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic u1, input logic [4:0] rs2, input logic u2);
        ID_EX_RegWrite    = wr;
        ID_EX_RegisterRd  = rd;
        IF_ID_RegisterRs1 = rs1;
        IF_ID_UsesRs1     = u1;
        IF_ID_RegisterRs2 = rs2;
        IF_ID_UsesRs2     = u2;
    endtask

    // Inputs are applied just after a rising edge; controls are sampled on the falling edge.
    task automatic cycle(input string tag, input logic [7:0] exp_ctrl);
        @(negedge clk);
        check(tag, {24'd0, ctrl}, {24'd0, exp_ctrl});
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag, input int stl, input int frz,
                                  input int fle, input logic tmo);
        check({tag, ".stall"},   stall_cycles,  stl);
        check({tag, ".freeze"},  freeze_cycles, frz);
        check({tag, ".flushev"}, flush_events,  fle);
        check({tag, ".timeout"}, {31'd0, mem_timeout}, {31'd0, tmo});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        cycle("rst0", C_FROZEN);
        cycle("rst1", C_FROZEN);
        rst = 1'b0;
        check_counters("post_rst", 0, 0, 0, 1'b0);
        cycle("post_rst_ctrl", C_NORMAL);

        // Distance-1 dependence on rs1: single bubble, then normal flow.
        set_dep(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        cycle("dep_rs1", C_STALL);
        set_dep(1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0);
        cycle("dep_after", C_NORMAL);
        check("dep_stall_cnt", stall_cycles, 1);

        set_dep(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        cycle("dep_rd0", C_NORMAL);
        set_dep(1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b0);
        cycle("dep_rs2_unused", C_NORMAL);
        set_dep(1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
        cycle("dep_no_regwrite", C_NORMAL);
        set_dep(1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
        cycle("dep_rs2", C_STALL);
        idle();
        check("dep_stall_cnt2", stall_cycles, 2);

        // Taken branch with a simultaneous hazard: branch wins, no stall counted.
        set_dep(1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        EX_BranchTaken = 1'b1;
        cycle("br_c0", C_BRANCH);
        EX_BranchTaken = 1'b0;
        cycle("br_c1", C_FLUSH);
        idle();
        cycle("br_c2", C_NORMAL);
        check_counters("br", 2, 0, 1, 1'b0);

        // Back-to-back branches: second one arrives in FLUSH and restarts it.
        EX_BranchTaken = 1'b1;
        cycle("b2b_c0", C_BRANCH);
        cycle("b2b_c1", C_BRANCH);
        EX_BranchTaken = 1'b0;
        cycle("b2b_c2", C_FLUSH);
        cycle("b2b_c3", C_NORMAL);
        check("b2b_flushev", flush_events, 3);

        // Freeze during a taken branch: redirect waits for dmem_ready.
        EX_BranchTaken = 1'b1;
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle($sformatf("frz_br%0d", i), C_FROZEN);
        dmem_ready = 1'b1;
        cycle("frz_br_release", C_BRANCH);
        idle();
        cycle("frz_br_flush", C_FLUSH);
        cycle("frz_br_run", C_NORMAL);
        check_counters("frz_br", 2, 3, 4, 1'b0);

        // Timeout: 5-cycle freeze with a pending hazard that must not be counted.
        set_dep(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle($sformatf("tmo_frz%0d", i), C_FROZEN);
        check("tmo_before", {31'd0, mem_timeout}, 32'd0);
        cycle("tmo_frz3", C_FROZEN);
        check("tmo_after4", {31'd0, mem_timeout}, 32'd1);
        cycle("tmo_frz4", C_FROZEN);
        idle();
        cycle("tmo_released", C_NORMAL);
        check_counters("tmo", 2, 8, 4, 1'b1);

        dmem_req = 1'b1;
        cycle("short_frz0", C_FROZEN);
        cycle("short_frz1", C_FROZEN);
        dmem_ready = 1'b1;
        cycle("short_ready", C_NORMAL);
        idle();
        check_counters("short", 2, 10, 4, 1'b1);

        // Reset in the middle of FLUSH returns to RUN with everything cleared.
        EX_BranchTaken = 1'b1;
        cycle("mid_br", C_BRANCH);
        EX_BranchTaken = 1'b0;
        rst = 1'b1;
        cycle("mid_rst0", C_FROZEN);
        cycle("mid_rst1", C_FROZEN);
        rst = 1'b0;
        check_counters("mid_rst", 0, 0, 0, 1'b0);
        cycle("mid_rst_run", C_NORMAL);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
